// File: rtl/display_scan_mux_if.sv
// Bundles the source-select/data inputs and the scan outputs of
// display_scan_mux. The master side is the producer of digit data and the
// consumer of anode/segment signals; the slave side is the scan controller.
interface display_scan_mux_if #(
    parameter int NUM_DIGITS = 4,
    parameter int NUM_CHAN   = 2,
    parameter int SEL_W      = 1
);
    logic [SEL_W-1:0]                 chan_sel;
    logic [NUM_CHAN*NUM_DIGITS*4-1:0] chan_data;
    logic [NUM_DIGITS-1:0]            digit_en;
    logic [3:0]                       seg_code;
    logic                             frame_done;

    modport master (
        output chan_sel,
        output chan_data,
        input  digit_en,
        input  seg_code,
        input  frame_done
    );

    modport slave (
        input  chan_sel,
        input  chan_data,
        output digit_en,
        output seg_code,
        output frame_done
    );
endinterface

// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scan controller.
// Once per frame (LOAD) the selected channel's digit nibbles are captured
// into a snapshot so mid-frame source changes never tear the display. Each
// digit is then driven for DIV_TERM cycles (SHOW), followed by GUARD_CYC
// all-off cycles (GUARD) to stop ghosting between anodes.
// All outputs are registered: on each edge the output registers take the
// values belonging to the state the controller was in before that edge.
// Optional build macro: LEADING_ZERO_BLANK_EN -- when defined, leading zero
// digits (other than digit 0) keep their anode off during their SHOW slot.
module display_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int NUM_CHAN   = 2,
    parameter int SEL_W      = 1,
    parameter int DIV_W      = 16,
    parameter int DIV_TERM   = 50000,
    parameter int GUARD_CYC  = 2
) (
    input  logic               clk,
    input  logic               rst,
    display_scan_mux_if.slave  bus
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int GRD_W  = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam int SNAP_W = NUM_DIGITS * 4;

    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(DIV_TERM - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [GRD_W-1:0]      GRD_LAST = GRD_W'((GUARD_CYC > 0) ? (GUARD_CYC - 1) : 0);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t                state_r;
    logic [IDX_W-1:0]      idx_r;
    logic [DIV_W-1:0]      div_r;
    logic [GRD_W-1:0]      grd_r;
    logic [SNAP_W-1:0]     snap_r;
    logic [NUM_DIGITS-1:0] digit_en_r;
    logic [3:0]            seg_code_r;
    logic                  frame_done_r;

    logic [SNAP_W-1:0]     sel_data_s;
    logic [NUM_DIGITS-1:0] show_mask_s;
`ifdef LEADING_ZERO_BLANK_EN
    logic                  upper_zero_s;
`endif

    assign bus.digit_en   = digit_en_r;
    assign bus.seg_code   = seg_code_r;
    assign bus.frame_done = frame_done_r;

    // Pick the selected channel's nibbles; out-of-range selects fall back to channel 0.
    always_comb begin
        sel_data_s = bus.chan_data[SNAP_W-1:0];
        if (int'(bus.chan_sel) < NUM_CHAN) begin
            sel_data_s = bus.chan_data[int'(bus.chan_sel)*SNAP_W +: SNAP_W];
        end else begin
            sel_data_s = bus.chan_data[SNAP_W-1:0];
        end
    end

    // Per-digit drive permission; leading zeros are suppressed only when blanking is built in.
    always_comb begin
        show_mask_s = '1;
`ifdef LEADING_ZERO_BLANK_EN
        upper_zero_s = 1'b1;
        for (int d = NUM_DIGITS - 1; d > 0; d--) begin
            upper_zero_s   = upper_zero_s & (snap_r[d*4 +: 4] == 4'h0);
            show_mask_s[d] = ~upper_zero_s;
        end
`endif
    end

    // Scan FSM with registered anode, segment and frame-strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_LOAD;
            idx_r        <= '0;
            div_r        <= '0;
            grd_r        <= '0;
            snap_r       <= '0;
            digit_en_r   <= '1;
            seg_code_r   <= 4'h0;
            frame_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    snap_r       <= sel_data_s;
                    frame_done_r <= 1'b1;
                    digit_en_r   <= '1;
                    idx_r        <= '0;
                    div_r        <= '0;
                    grd_r        <= '0;
                    state_r      <= ST_SHOW;
                end
                ST_SHOW: begin
                    frame_done_r <= 1'b0;
                    seg_code_r   <= snap_r[idx_r*4 +: 4];
                    if (show_mask_s[idx_r]) begin
                        digit_en_r <= ~(ONE_HOT << idx_r);
                    end else begin
                        digit_en_r <= '1;
                    end
                    if (div_r == DIV_LAST) begin
                        div_r <= '0;
                        if (GUARD_CYC > 0) begin
                            state_r <= ST_GUARD;
                        end else if (idx_r == IDX_LAST) begin
                            state_r <= ST_LOAD;
                        end else begin
                            idx_r   <= idx_r + 1'b1;
                            state_r <= ST_SHOW;
                        end
                    end else begin
                        div_r <= div_r + 1'b1;
                    end
                end
                ST_GUARD: begin
                    frame_done_r <= 1'b0;
                    digit_en_r   <= '1;
                    if (grd_r == GRD_LAST) begin
                        grd_r <= '0;
                        if (idx_r == IDX_LAST) begin
                            state_r <= ST_LOAD;
                        end else begin
                            idx_r   <= idx_r + 1'b1;
                            state_r <= ST_SHOW;
                        end
                    end else begin
                        grd_r <= grd_r + 1'b1;
                    end
                end
                default: begin
                    frame_done_r <= 1'b0;
                    digit_en_r   <= '1;
                    state_r      <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: two instances run side by side.
//   dut_a: 4 digits, 2 channels, DIV_TERM=4, GUARD_CYC=1 (21-cycle frame)
//   dut_b: 4 digits, 3 channels (SEL_W=2), DIV_TERM=4, GUARD_CYC=0 (17-cycle frame)
// The reference model expands each captured snapshot into the whole frame's
// expected output sequence and replays it one cycle at a time.
module tb_display_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a;
    logic        rst_b;
    logic [0:0]  sel_a;
    logic [31:0] data_a;
    logic [1:0]  sel_b;
    logic [47:0] data_b;

    display_scan_mux_if #(.NUM_DIGITS(4), .NUM_CHAN(2), .SEL_W(1)) ifa ();
    display_scan_mux_if #(.NUM_DIGITS(4), .NUM_CHAN(3), .SEL_W(2)) ifb ();

    assign ifa.chan_sel  = sel_a;
    assign ifa.chan_data = data_a;
    assign ifb.chan_sel  = sel_b;
    assign ifb.chan_data = data_b;

    display_scan_mux #(
        .NUM_DIGITS(4), .NUM_CHAN(2), .SEL_W(1),
        .DIV_W(16), .DIV_TERM(4), .GUARD_CYC(1)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    display_scan_mux #(
        .NUM_DIGITS(4), .NUM_CHAN(3), .SEL_W(2),
        .DIV_W(8), .DIV_TERM(4), .GUARD_CYC(0)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    // reference model state: one expanded frame per instance
    logic [3:0] f_en  [2][64];
    logic [3:0] f_seg [2][64];
    logic       f_fd  [2][64];
    int         pos [2];
    int         len [2];
    logic [3:0] last_seg [2];
    logic [3:0] exp_en  [2];
    logic [3:0] exp_seg [2];
    logic       exp_fd  [2];

    int vectors;
    int miscompares;
    int cyc;

    logic [3:0] dir_en [7];

    function automatic void build_frame(input int k);
        logic [47:0] dv;
        logic [15:0] snap;
        logic [3:0]  nib;
        logic        shown;
        int s, nch, g, c, n;
        if (k == 0) begin
            dv = {16'h0000, data_a}; s = int'(sel_a); nch = 2; g = 1;
        end else begin
            dv = data_b; s = int'(sel_b); nch = 3; g = 0;
        end
        c = (s < nch) ? s : 0;
        snap = dv[c*16 +: 16];
        n = 0;
        f_en[k][n] = 4'hF; f_seg[k][n] = last_seg[k]; f_fd[k][n] = 1'b1; n++;
        for (int d = 0; d < 4; d++) begin
            nib   = snap[d*4 +: 4];
            shown = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            if (d > 0 && (snap >> (4*d)) == 16'h0000) shown = 1'b0;
`endif
            for (int i = 0; i < 4; i++) begin
                f_en[k][n]  = shown ? ~(4'b0001 << d) : 4'hF;
                f_seg[k][n] = nib; f_fd[k][n] = 1'b0; n++;
            end
            for (int i = 0; i < g; i++) begin
                f_en[k][n] = 4'hF; f_seg[k][n] = nib; f_fd[k][n] = 1'b0; n++;
            end
        end
        last_seg[k] = snap[15:12];
        len[k] = n;
        pos[k] = 0;
    endfunction

    // advance one clock and compute what each instance should now show
    task automatic step();
        logic rs0, rs1;
        rs0 = rst_a;
        rs1 = rst_b;
        if (!rs0 && pos[0] >= len[0]) build_frame(0);
        if (!rs1 && pos[1] >= len[1]) build_frame(1);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if ((k == 0) ? rs0 : rs1) begin
                exp_en[k] = 4'hF; exp_seg[k] = 4'h0; exp_fd[k] = 1'b0;
                last_seg[k] = 4'h0; pos[k] = 0; len[k] = 0;
            end else begin
                exp_en[k] = f_en[k][pos[k]]; exp_seg[k] = f_seg[k][pos[k]];
                exp_fd[k] = f_fd[k][pos[k]]; pos[k]++;
            end
        end
    endtask

    function automatic logic [17:0] obs_vec();
        return {ifa.digit_en, ifa.seg_code, ifa.frame_done,
                ifb.digit_en, ifb.seg_code, ifb.frame_done};
    endfunction

    function automatic logic [17:0] exp_vec();
        return {exp_en[0], exp_seg[0], exp_fd[0], exp_en[1], exp_seg[1], exp_fd[1]};
    endfunction

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        sel_a = 1'b0; data_a = {16'h9876, 16'h4321};
        sel_b = 2'd0; data_b = {16'hABCD, 16'h5678, 16'h4321};
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec() || ifa.digit_en !== 4'hF || ifa.seg_code !== 4'h0) begin
                miscompares++;
                $display("FAIL reset cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
        end
        rst_a = 1'b0; rst_b = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec() || ifa.digit_en !== dir_en[i] ||
                ifa.frame_done !== ((i == 0) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL startup cyc %0d: got %h (en %b) expected %h (en %b)",
                         cyc, obs_vec(), ifa.digit_en, exp_vec(), dir_en[i]);
            end
        end
    endtask

    task automatic test_scan_period();
        int prev_a, prev_b, per_a, per_b;
        prev_a = -1; prev_b = -1; per_a = 0; per_b = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL scan cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
            if (ifa.frame_done === 1'b1) begin
                if (prev_a >= 0) per_a = cyc - prev_a;
                prev_a = cyc;
            end
            if (ifb.frame_done === 1'b1) begin
                if (prev_b >= 0) per_b = cyc - prev_b;
                prev_b = cyc;
            end
        end
        vectors++;
        if (per_a !== 21 || per_b !== 17) begin
            miscompares++;
            $display("FAIL frame_period: got a=%0d b=%0d expected a=21 b=17", per_a, per_b);
        end
    endtask

    task automatic test_snapshot();
        for (int i = 0; i < 50; i++) begin
            if (i == 8) begin
                sel_a  = 1'b1;
                data_a = {$urandom_range(0, 65535), 16'h4321};
                data_b = {$urandom(), $urandom()};
            end
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL snapshot cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_out_of_range();
        sel_b  = 2'd3;
        data_b = {$urandom(), $urandom()};
        for (int i = 0; i < 40; i++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL sel_out_of_range cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 12; it++) begin
            sel_a  = 1'($urandom_range(0, 1));
            data_a = $urandom();
            sel_b  = 2'($urandom_range(0, 3));
            data_b = {$urandom(), $urandom()};
            n = $urandom_range(5, 30);
            for (int i = 0; i < n; i++) begin
                step();
                vectors++;
                if (obs_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL random cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_reset_mid_show();
        int guard;
        guard = 0;
        while (pos[1] != 11 && guard < 40) begin
            step();
            guard++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL pre_reset cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (pos[1] != 11) begin
            miscompares++;
            $display("FAIL reach_digit2 timeout: got pos %0d expected 11", pos[1]);
        end
        rst_b = 1'b1;
        step();
        vectors++;
        if (obs_vec() !== exp_vec() || ifb.digit_en !== 4'hF) begin
            miscompares++;
            $display("FAIL mid_show_reset cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
        end
        rst_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec() ||
                (i == 0 && ifb.frame_done !== 1'b1) ||
                (i == 1 && ifb.digit_en !== 4'b1110)) begin
                miscompares++;
                $display("FAIL restart cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_leading_zero();
        sel_a  = 1'b0;
        data_a = {16'h1234, 16'h0007};
        sel_b  = 2'd1;
        data_b = {16'h0000, 16'h0000, 16'h0500};
        for (int i = 0; i < 45; i++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL lead_zero_7 cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
        end
        data_a = {16'h1234, 16'h0000};
        for (int i = 0; i < 45; i++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL lead_zero_0 cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        pos[0] = 0; pos[1] = 0; len[0] = 0; len[1] = 0;
        last_seg[0] = 4'h0; last_seg[1] = 4'h0;
        dir_en = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD};
        rst_a = 1'b1; rst_b = 1'b1;
        sel_a = 1'b0; sel_b = 2'd0; data_a = '0; data_b = '0;
        test_reset();
        test_scan_period();
        test_snapshot();
        test_out_of_range();
        test_random();
        test_reset_mid_show();
        test_leading_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
